// File: rtl/des_ctrl_pkg.sv
// Shared constants for the DES control blocks: FSM encoding, block width and
// the default core latency used by the arbiter, sender and Trojan-detection logic.
package des_ctrl_pkg;

  localparam int DES_BLOCK_W         = 64;
  localparam int DES_LATENCY_DEFAULT = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } des_state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant of the first request found
// searching upward from the priority pointer, wrapping at NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  // Scan from ptr with wrap; the first asserted request wins.
  always_comb begin
    logic             found_s;
    logic [PTR_W-1:0] idx_s;
    grant   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/des_request_arbiter.sv
// Shares one DES core between NUM_REQ requesters: round-robin grant, cs pulse,
// fixed-latency wait, ciphertext capture and a valid/ready response.
module des_request_arbiter
  import des_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DES_LATENCY = DES_LATENCY_DEFAULT,
  parameter int CNT_W       = 5
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NUM_REQ-1:0]             REQ_VALID,
  input  logic [NUM_REQ-1:0]             REQ_ADDR,
  input  logic [DES_BLOCK_W*NUM_REQ-1:0] REQ_PLAIN,
  output logic [NUM_REQ-1:0]             REQ_ACCEPT,
  output logic [NUM_REQ-1:0]             RSP_VALID,
  input  logic [NUM_REQ-1:0]             RSP_READY,
  output logic [DES_BLOCK_W-1:0]         RSP_CIPHER,
  output logic                           DES_CS,
  output logic                           DES_ADDR,
  output logic [DES_BLOCK_W-1:0]         DES_PLAIN,
  input  logic [DES_BLOCK_W-1:0]         DES_CIPHER,
  output logic                           BUSY
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  des_state_e             state_r, next_state_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [PTR_W-1:0]       ptr_r, next_ptr_s, gidx_s;
  logic [NUM_REQ-1:0]     arb_grant_s, gnt_r, accept_r, rsp_valid_r;
  logic [DES_BLOCK_W-1:0] rsp_cipher_r, des_plain_r;
  logic                   des_addr_r, des_cs_r, busy_r;
  logic                   take_s, capture_s, rsp_done_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req   (REQ_VALID),
    .ptr   (ptr_r),
    .grant (arb_grant_s)
  );

  // Encode the one-hot grant and derive the pointer that follows it.
  always_comb begin
    gidx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gidx_s = arb_grant_s[i] ? PTR_W'(i) : gidx_s;
    end
    next_ptr_s = (int'(gidx_s) == NUM_REQ - 1) ? '0 : gidx_s + PTR_W'(1);
  end

  // Next-state logic; only RSP_READY of the granted requester ends RESP.
  always_comb begin
    next_state_s = state_r;
    take_s       = 1'b0;
    capture_s    = 1'b0;
    rsp_done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|REQ_VALID) begin
          take_s       = 1'b1;
          next_state_s = ST_LOAD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD: next_state_s = ST_WAIT;
      ST_WAIT: begin
        if (cnt_r == CNT_W'(DES_LATENCY - 1)) begin
          capture_s    = 1'b1;
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (|(RSP_READY & rsp_valid_r)) begin
          rsp_done_s   = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs; reset discards any pending result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      ptr_r        <= '0;
      gnt_r        <= '0;
      accept_r     <= '0;
      rsp_valid_r  <= '0;
      rsp_cipher_r <= '0;
      des_plain_r  <= '0;
      des_addr_r   <= 1'b0;
      des_cs_r     <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      accept_r <= take_s ? arb_grant_s : '0;
      des_cs_r <= (state_r == ST_LOAD);
      busy_r   <= (next_state_s != ST_IDLE);
      if (take_s) begin
        gnt_r       <= arb_grant_s;
        ptr_r       <= next_ptr_s;
        des_plain_r <= REQ_PLAIN[int'(gidx_s)*DES_BLOCK_W +: DES_BLOCK_W];
        des_addr_r  <= REQ_ADDR[gidx_s];
      end
      if (state_r == ST_LOAD) begin
        cnt_r <= '0;
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (capture_s) begin
        rsp_cipher_r <= DES_CIPHER;
      end
      // RSP_VALID rises one cycle after capture and holds until the handshake.
      if (rsp_done_s) begin
        rsp_valid_r <= '0;
      end else if (state_r == ST_RESP) begin
        rsp_valid_r <= gnt_r;
      end
    end
  end

  assign REQ_ACCEPT = accept_r;
  assign RSP_VALID  = rsp_valid_r;
  assign RSP_CIPHER = rsp_cipher_r;
  assign DES_CS     = des_cs_r;
  assign DES_ADDR   = des_addr_r;
  assign DES_PLAIN  = des_plain_r;
  assign BUSY       = busy_r;

endmodule

// File: doc/des_request_arbiter.md
Name: des_request_arbiter

Overview:
Shares one Des_Top encryption core between NUM_REQ independent requesters, e.g. the host plaintext path and an RS232 loop-back path.
- Arbitrates with round-robin and drives the core's chip-select, address and plaintext inputs.
- Waits the fixed core latency, captures the ciphertext and returns it to the winning requester with a valid/ready handshake.
- Sits directly between the requesters and the DES core and replaces ad-hoc busy/cs gating logic.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
DES_LATENCY, 17, cycles from the cs pulse to a valid CIPHER_TEXT (1..31)
CNT_W, 5, latency counter width; must satisfy 2**CNT_W > DES_LATENCY

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
REQ_VALID  in  NUM_REQ  per-requester request
REQ_ADDR  in  NUM_REQ  per-requester DES ADDRESS bit
REQ_PLAIN  in  64*NUM_REQ  packed plaintexts; requester i uses bits [64*i+63:64*i]
REQ_ACCEPT  out  NUM_REQ  one-hot, 1-cycle pulse when a request is taken
RSP_VALID  out  NUM_REQ  one-hot, result valid for requester i
RSP_READY  in  NUM_REQ  requester i consumes its result
RSP_CIPHER  out  64  captured ciphertext, shared by all requesters
DES_CS  out  1  chip-select to core, 1-cycle pulse
DES_ADDR  out  1  address to core
DES_PLAIN  out  64  plaintext to core
DES_CIPHER  in  64  core CIPHER_TEXT
BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, RST=1 at a rising edge) outputs:
  - REQ_ACCEPT=0, RSP_VALID=0, RSP_CIPHER=0, DES_CS=0, DES_ADDR=0, DES_PLAIN=0, BUSY=0.
  - State=IDLE, latency counter=0.
  - Round-robin pointer set so requester 0 has top priority.
- Reset in any state aborts the operation immediately; a pending result is discarded.
- States: IDLE -> LOAD -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any REQ_VALID is set, grant the first set bit searching upward (with wrap) from the priority pointer.
  - Pulse REQ_ACCEPT[g] for one cycle.
  - Latch REQ_PLAIN slice g into DES_PLAIN and REQ_ADDR[g] into DES_ADDR.
  - Store g; move the pointer to g+1 mod NUM_REQ; go to LOAD.
  - If no REQ_VALID is set, stay in IDLE.
- LOAD: DES_CS=1 for exactly this cycle; counter cleared to 0; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - When counter==DES_LATENCY-1: capture DES_CIPHER into RSP_CIPHER and go to RESP.
  - The capture edge is DES_LATENCY cycles after the DES_CS edge.
- RESP:
  - RSP_VALID[g]=1 and is held.
  - RSP_CIPHER is stable until RSP_READY[g]=1 is sampled.
  - On that edge, clear RSP_VALID and go to IDLE.
  - RSP_READY bits of non-granted requesters are ignored.
- DES_PLAIN and DES_ADDR hold their values from the accept edge until the next accept; DES_CS is 0 outside LOAD.
- Latency: accept edge at T -> DES_CS high T+1..T+2 -> RSP_VALID rises at T+2+DES_LATENCY.
- Minimum spacing between two accepts is DES_LATENCY+4 cycles: a RESP of 1 cycle plus 1 IDLE cycle.
- REQ_VALID is sampled only in IDLE. Requesters must hold REQ_VALID and REQ_PLAIN stable until they see REQ_ACCEPT; requests arriving outside IDLE wait.
- Simultaneous requests: exactly one grant per IDLE cycle. The loser stays pending and wins the next arbitration if it is still valid (starvation-free).
- REQ_VALID[g] dropping during LOAD, WAIT or RESP has no effect; the operation completes.

Decomposition:
- Shared package des_ctrl_pkg holds:
  - state encoding constants ST_IDLE=0, ST_LOAD=1, ST_WAIT=2, ST_RESP=3;
  - DES_BLOCK_W=64;
  - the default DES_LATENCY=17, so the sender and Trojan-detection blocks share it.
- One natural sub-module: rr_arbiter. It is combinational: request vector plus pointer in, one-hot grant out. The pointer register stays in des_request_arbiter.

Test Plan:
- Single request: REQ_VALID=01, REQ_PLAIN[63:0]=64'h0123456789ABCDEF, model core returns 64'h85E813540F0AB405 17 cycles after cs -> REQ_ACCEPT=01 at T, DES_CS pulse at T+1, RSP_VALID=01 at T+19 with that ciphertext, cleared one cycle after RSP_READY=01.
- Contention: REQ_VALID=11 held continuously -> grants alternate 01,10,01,10 across four operations; each accept is 21 cycles apart when RSP_READY is tied high.
- Backpressure: RSP_READY held 0 for 50 cycles while requester 1 is valid -> RSP_VALID and RSP_CIPHER stay stable, no new accept and no DES_CS until READY rises.
- Reset mid-WAIT: RST=1 at counter=8 -> next cycle all outputs 0 and state IDLE; the pending request with REQ_VALID=10 then wins as requester 1 only if requester 0 is idle; no stale RSP_VALID.
- Wrong-ready ignored: in RESP for requester 0, RSP_READY=10 -> RSP_VALID stays 01.
- DES_LATENCY=1 build: accept edge at T -> RSP_VALID at T+3; capture occurs on the cycle after cs.
